lsu_ctrl: RTL and testbench

//  Parametrised load/store unit between the core's execute stage and the data-memory bus.

---
 rtl/lsu_pkg.sv | 50 +++++
 rtl/lsu_align.sv | 70 +++++++
 rtl/lsu_ctrl.sv | 159 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   FUNC3_*       RISC-V funct3 encodings for loads and stores
//   lsu_state_e   controller states IDLE / BUS / RESP
//   func3_legal   legality of a funct3 for a load or a store at the given XLEN
//   misaligned    natural-alignment check on the low address bits
package lsu_pkg;

  localparam logic [2:0] FUNC3_B  = 3'b000;
  localparam logic [2:0] FUNC3_H  = 3'b001;
  localparam logic [2:0] FUNC3_W  = 3'b010;
  localparam logic [2:0] FUNC3_D  = 3'b011;
  localparam logic [2:0] FUNC3_BU = 3'b100;
  localparam logic [2:0] FUNC3_HU = 3'b101;
  localparam logic [2:0] FUNC3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  // Stores only exist in signed-width form; unsigned variants are loads only.
  function automatic logic func3_legal(input logic we, input logic [2:0] f3,
                                       input logic xlen64);
    logic ok;
    ok = 1'b0;
    case (f3)
      FUNC3_B, FUNC3_H, FUNC3_W: ok = 1'b1;
      FUNC3_D:                   ok = xlen64;
      FUNC3_BU, FUNC3_HU:        ok = ~we;
      FUNC3_WU:                  ok = ~we & xlen64;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Access size lives in f3[1:0] for both signed and unsigned forms.
  function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] a);
    logic bad;
    bad = 1'b0;
    case (f3[1:0])
      2'b01:   bad = a[0];
      2'b10:   bad = |a[1:0];
      2'b11:   bad = |a;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the load/store unit.
//   func3_i  latched funct3 (size in [1:0], unsigned flag in [2])
//   off_i    byte offset of the access within the bus word
//   wdata_i  right-aligned store data
//   rdata_i  raw bus read data
//   be_o     byte enables for the access
//   wdata_o  store datum replicated across every lane of its size
//   rdata_o  load data shifted down and sign/zero-extended to XLEN
module lsu_align
  import lsu_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int BE_W  = XLEN / 8,
  localparam int OFF_W = $clog2(BE_W)
) (
  input  logic [2:0]       func3_i,
  input  logic [OFF_W-1:0] off_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic [XLEN-1:0]  rdata_i,
  output logic [BE_W-1:0]  be_o,
  output logic [XLEN-1:0]  wdata_o,
  output logic [XLEN-1:0]  rdata_o
);

  logic [XLEN-1:0]    rsh;
  logic signed [7:0]  b_s;
  logic signed [15:0] h_s;
  logic signed [31:0] w_s;

  always_comb begin
    be_o    = '1;
    wdata_o = wdata_i;
    case (func3_i[1:0])
      2'b00: begin
        be_o    = BE_W'(1) << off_i;
        wdata_o = {BE_W{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = BE_W'(3) << off_i;
        wdata_o = {(XLEN/16){wdata_i[15:0]}};
      end
      2'b10: begin
        be_o    = BE_W'(15) << off_i;
        wdata_o = {(XLEN/32){wdata_i[31:0]}};
      end
      default: begin
        be_o    = '1;
        wdata_o = wdata_i;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend from its width.
  always_comb begin
    rsh = rdata_i >> {off_i, 3'b000};
    b_s = rsh[7:0];
    h_s = rsh[15:0];
    w_s = rsh[31:0];
    case (func3_i)
      FUNC3_B:  rdata_o = XLEN'(b_s);
      FUNC3_H:  rdata_o = XLEN'(h_s);
      FUNC3_W:  rdata_o = XLEN'(w_s);
      FUNC3_BU: rdata_o = XLEN'(rsh[7:0]);
      FUNC3_HU: rdata_o = XLEN'(rsh[15:0]);
      FUNC3_WU: rdata_o = XLEN'(rsh[31:0]);
      default:  rdata_o = rsh;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between execute stage and data-memory bus.
//   Core side : req_valid/req_ready handshake with we, func3, addr, wdata, rd;
//               one-cycle resp_valid with resp_wen/resp_rdata/resp_rd/resp_err;
//               busy stalls the core whenever the unit is not IDLE.
//   Bus side  : bus_valid held with stable we/addr/be/wdata until bus_ready;
//               bus_rdata sampled together with bus_ready.
//   Debug     : dbg_state exposes the FSM state.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE and requests presented elsewhere are dropped.
// A bus access completes on the first rising edge with bus_valid && bus_ready.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter int TMO_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  output logic              resp_wen,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_err,
  output logic              busy,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [XLEN/8-1:0] bus_be,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic              bus_ready,
  input  logic [XLEN-1:0]   bus_rdata,
  output logic [1:0]        dbg_state
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam bit TMO_EN = (TIMEOUT_CYC != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_EN ? TIMEOUT_CYC - 1 : 0);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [4:0]        rd_q, rd_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;

  logic [BE_W-1:0]   be;
  logic [XLEN-1:0]   wdata_rep;
  logic [XLEN-1:0]   load_ext;

  lsu_align #(.XLEN(XLEN)) u_align (
    .func3_i (f3_q),
    .off_i   (addr_q[OFF_W-1:0]),
    .wdata_i (wdata_q),
    .rdata_i (bus_rdata),
    .be_o    (be),
    .wdata_o (wdata_rep),
    .rdata_o (load_ext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_func3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rd_d    = req_rd;
          rdata_d = '0;
          cnt_d   = '0;
          // Illegal or misaligned requests skip the bus entirely.
          if (func3_legal(req_we, req_func3, XLEN == 64) &&
              !misaligned(req_func3, req_addr[2:0])) begin
            err_d   = 1'b0;
            state_d = BUS;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      BUS: begin
        // bus_ready is checked first so a reply in the expiry cycle is not an error.
        if (bus_ready) begin
          rdata_d = we_q ? '0 : load_ext;
          state_d = RESP;
        end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = ~req_ready;
  assign bus_valid  = (state_q == BUS);
  assign bus_we     = bus_valid & we_q;
  assign bus_addr   = bus_valid ? {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)} : '0;
  assign bus_be     = bus_valid ? be : '0;
  assign bus_wdata  = (bus_valid && we_q) ? wdata_rep : '0;
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_wen   = resp_valid & ~we_q & ~err_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_rd    = rd_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: bench for lsu_ctrl with one XLEN=32 and one XLEN=64 instance,
// both with a 4-cycle bus timeout. sel picks which instance the shared
// stimulus drives and which outputs are observed.
module tb_lsu_ctrl;

  typedef struct {
    logic        sel;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic [63:0] rdata;
    logic        exp_bus;
    logic [31:0] exp_baddr;
    logic [7:0]  exp_be;
    logic [63:0] exp_bwdata;
    logic        exp_err;
    logic        exp_wen;
    logic [63:0] exp_rdata;
  } vec_t;

  localparam int NV = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_func3 = '0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        bus_ready = 1'b0;
  logic [63:0] bus_rdata = '0;

  logic        rv32, rv64, bv32, bv64;
  logic        r32_req_ready, r32_resp_valid, r32_resp_wen, r32_resp_err, r32_busy;
  logic        r32_bus_valid, r32_bus_we;
  logic [31:0] r32_resp_rdata, r32_bus_addr, r32_bus_wdata;
  logic [4:0]  r32_resp_rd;
  logic [3:0]  r32_bus_be;
  logic [1:0]  r32_dbg;
  logic        r64_req_ready, r64_resp_valid, r64_resp_wen, r64_resp_err, r64_busy;
  logic        r64_bus_valid, r64_bus_we;
  logic [63:0] r64_resp_rdata, r64_bus_wdata;
  logic [31:0] r64_bus_addr;
  logic [4:0]  r64_resp_rd;
  logic [7:0]  r64_bus_be;
  logic [1:0]  r64_dbg;

  logic        o_req_ready, o_resp_valid, o_resp_wen, o_resp_err, o_busy;
  logic        o_bus_valid, o_bus_we;
  logic [63:0] o_resp_rdata, o_bus_wdata;
  logic [31:0] o_bus_addr;
  logic [4:0]  o_resp_rd;
  logic [7:0]  o_bus_be;

  logic [65:0] exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  vec_t vecs[NV];

  assign rv32 = req_valid & ~sel;
  assign rv64 = req_valid & sel;
  assign bv32 = bus_ready & ~sel;
  assign bv64 = bus_ready & sel;

  always #5 clk = ~clk;

  lsu_ctrl #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(4), .TMO_W(3)) u_dut32 (
    .clk(clk), .reset(reset),
    .req_valid(rv32), .req_ready(r32_req_ready), .req_we(req_we),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .req_rd(req_rd),
    .resp_valid(r32_resp_valid), .resp_wen(r32_resp_wen), .resp_rdata(r32_resp_rdata),
    .resp_rd(r32_resp_rd), .resp_err(r32_resp_err), .busy(r32_busy),
    .bus_valid(r32_bus_valid), .bus_we(r32_bus_we), .bus_addr(r32_bus_addr),
    .bus_be(r32_bus_be), .bus_wdata(r32_bus_wdata), .bus_ready(bv32),
    .bus_rdata(bus_rdata[31:0]), .dbg_state(r32_dbg)
  );

  lsu_ctrl #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYC(4), .TMO_W(3)) u_dut64 (
    .clk(clk), .reset(reset),
    .req_valid(rv64), .req_ready(r64_req_ready), .req_we(req_we),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .resp_valid(r64_resp_valid), .resp_wen(r64_resp_wen), .resp_rdata(r64_resp_rdata),
    .resp_rd(r64_resp_rd), .resp_err(r64_resp_err), .busy(r64_busy),
    .bus_valid(r64_bus_valid), .bus_we(r64_bus_we), .bus_addr(r64_bus_addr),
    .bus_be(r64_bus_be), .bus_wdata(r64_bus_wdata), .bus_ready(bv64),
    .bus_rdata(bus_rdata), .dbg_state(r64_dbg)
  );

  always_comb begin
    o_req_ready  = sel ? r64_req_ready  : r32_req_ready;
    o_resp_valid = sel ? r64_resp_valid : r32_resp_valid;
    o_resp_wen   = sel ? r64_resp_wen   : r32_resp_wen;
    o_resp_err   = sel ? r64_resp_err   : r32_resp_err;
    o_resp_rdata = sel ? r64_resp_rdata : {32'd0, r32_resp_rdata};
    o_resp_rd    = sel ? r64_resp_rd    : r32_resp_rd;
    o_busy       = sel ? r64_busy       : r32_busy;
    o_bus_valid  = sel ? r64_bus_valid  : r32_bus_valid;
    o_bus_we     = sel ? r64_bus_we     : r32_bus_we;
    o_bus_addr   = sel ? r64_bus_addr   : r32_bus_addr;
    o_bus_be     = sel ? r64_bus_be     : {4'd0, r32_bus_be};
    o_bus_wdata  = sel ? r64_bus_wdata  : {32'd0, r32_bus_wdata};
  end

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_resp();
    logic [65:0] e;
    if (exp_q.size() == 0) begin
      chk("resp_unexpected", 66'd1, 66'd0);
    end else begin
      e = exp_q.pop_front();
      chk("resp_err_wen_rdata", {o_resp_err, o_resp_wen, o_resp_rdata}, e);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [63:0] wd,
                              input logic [4:0] rd, input logic [63:0] bus_rd,
                              input logic eb, input logic [31:0] ba, input logic [7:0] be,
                              input logic [63:0] bwd, input logic err, input logic wen,
                              input logic [63:0] rdv);
    vec_t v;
    v.sel = s; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.rd = rd;
    v.rdata = bus_rd; v.exp_bus = eb; v.exp_baddr = ba; v.exp_be = be;
    v.exp_bwdata = bwd; v.exp_err = err; v.exp_wen = wen; v.exp_rdata = rdv;
    return v;
  endfunction

  // Issue one request at the next negedge, answer the bus immediately, and
  // check the response. Returns on the negedge where resp_valid is seen, so a
  // following call issues back-to-back.
  task automatic run_vec(input vec_t v);
    logic bus_seen;
    logic got;
    sel = v.sel;
    @(negedge clk);
    chk("resp_one_cycle", {65'd0, o_resp_valid}, 66'd0);
    chk("req_ready_idle", {65'd0, o_req_ready}, 66'd1);
    req_valid = 1'b1; req_we = v.we; req_func3 = v.f3; req_addr = v.addr;
    req_wdata = v.wdata; req_rd = v.rd;
    exp_q.push_back({v.exp_err, v.exp_wen, v.exp_rdata});
    @(negedge clk);
    req_valid = 1'b0;
    bus_seen = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      if (o_resp_valid) begin
        got = 1'b1;
        check_resp();
        chk("resp_rd", {61'd0, o_resp_rd}, {61'd0, v.rd});
        chk("bus_access", {65'd0, bus_seen}, {65'd0, v.exp_bus});
      end else begin
        if (o_bus_valid && !bus_seen) begin
          bus_seen = 1'b1;
          chk("bus_addr", {34'd0, o_bus_addr}, {34'd0, v.exp_baddr});
          chk("bus_be", {58'd0, o_bus_be}, {58'd0, v.exp_be});
          chk("bus_we", {65'd0, o_bus_we}, {65'd0, v.we});
          if (v.we) chk("bus_wdata", {2'd0, o_bus_wdata}, {2'd0, v.exp_bwdata});
          bus_ready = 1'b1;
          bus_rdata = v.rdata;
        end
        @(negedge clk);
        bus_ready = 1'b0;
      end
    end
    if (!got) chk("resp_timeout", 66'd0, 66'd1);
  endtask

  // LW on the 32-bit unit; ready_at = bus cycle number (1-based) that gets
  // bus_ready, 0 = never answer.
  task automatic tmo_seq(input int ready_at);
    int n_bus;
    logic got;
    logic stable;
    sel = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h300;
    req_rd = 5'd7;
    if (ready_at == 0) exp_q.push_back({1'b1, 1'b0, 64'd0});
    else               exp_q.push_back({1'b0, 1'b1, 64'h55});
    @(negedge clk);
    req_valid = 1'b0;
    n_bus = 0; got = 1'b0; stable = 1'b1;
    for (int c = 0; c < 50 && !got; c++) begin
      if (o_resp_valid) begin
        got = 1'b1;
        check_resp();
      end else begin
        if (o_bus_valid) begin
          n_bus++;
          if (o_bus_addr !== 32'h300 || o_bus_be !== 8'h0F) stable = 1'b0;
          if (n_bus == ready_at) begin
            bus_ready = 1'b1;
            bus_rdata = 64'h55;
          end
        end
        @(negedge clk);
        bus_ready = 1'b0;
      end
    end
    if (!got) chk("tmo_resp_timeout", 66'd0, 66'd1);
    chk("tmo_bus_cycles", 66'(n_bus), 66'd4);
    chk("tmo_bus_stable", {65'd0, stable}, 66'd1);
  endtask

  initial begin
    vecs[0]  = mk(0, 1, 3'b000, 32'h103, 64'hAB, 5'd1, 64'h0, 1, 32'h100, 8'h08,
                  64'hABABABAB, 0, 0, 64'h0);
    vecs[1]  = mk(0, 0, 3'b000, 32'h101, 64'h0, 5'd2, 64'h8000, 1, 32'h100, 8'h02,
                  64'h0, 0, 1, 64'hFFFFFF80);
    vecs[2]  = mk(0, 0, 3'b100, 32'h101, 64'h0, 5'd3, 64'h8000, 1, 32'h100, 8'h02,
                  64'h0, 0, 1, 64'h80);
    vecs[3]  = mk(0, 0, 3'b010, 32'h102, 64'h0, 5'd4, 64'h0, 0, 32'h0, 8'h00,
                  64'h0, 1, 0, 64'h0);
    vecs[4]  = mk(0, 1, 3'b001, 32'h102, 64'h1234, 5'd5, 64'h0, 1, 32'h100, 8'h0C,
                  64'h12341234, 0, 0, 64'h0);
    vecs[5]  = mk(0, 0, 3'b001, 32'h102, 64'h0, 5'd6, 64'hF00D0000, 1, 32'h100, 8'h0C,
                  64'h0, 0, 1, 64'hFFFFF00D);
    vecs[6]  = mk(0, 0, 3'b101, 32'h106, 64'h0, 5'd7, 64'h80010000, 1, 32'h104, 8'h0C,
                  64'h0, 0, 1, 64'h8001);
    vecs[7]  = mk(0, 0, 3'b010, 32'h208, 64'h0, 5'd8, 64'hDEADBEEF, 1, 32'h208, 8'h0F,
                  64'h0, 0, 1, 64'hDEADBEEF);
    vecs[8]  = mk(0, 1, 3'b010, 32'h20C, 64'hCAFEF00D, 5'd9, 64'h0, 1, 32'h20C, 8'h0F,
                  64'hCAFEF00D, 0, 0, 64'h0);
    vecs[9]  = mk(0, 0, 3'b011, 32'h200, 64'h0, 5'd10, 64'h0, 0, 32'h0, 8'h00,
                  64'h0, 1, 0, 64'h0);
    vecs[10] = mk(0, 1, 3'b001, 32'h101, 64'h77, 5'd11, 64'h0, 0, 32'h0, 8'h00,
                  64'h0, 1, 0, 64'h0);
    vecs[11] = mk(0, 0, 3'b111, 32'h100, 64'h0, 5'd12, 64'h0, 0, 32'h0, 8'h00,
                  64'h0, 1, 0, 64'h0);
    vecs[12] = mk(0, 0, 3'b110, 32'h100, 64'h0, 5'd13, 64'h0, 0, 32'h0, 8'h00,
                  64'h0, 1, 0, 64'h0);
    vecs[13] = mk(1, 0, 3'b110, 32'h204, 64'h0, 5'd14, 64'h8000_0001_0000_0000, 1,
                  32'h200, 8'hF0, 64'h0, 0, 1, 64'h0000_0000_8000_0001);
    vecs[14] = mk(1, 1, 3'b110, 32'h204, 64'h1, 5'd15, 64'h0, 0, 32'h0, 8'h00,
                  64'h0, 1, 0, 64'h0);
    vecs[15] = mk(1, 0, 3'b011, 32'h208, 64'h0, 5'd16, 64'h0123_4567_89AB_CDEF, 1,
                  32'h208, 8'hFF, 64'h0, 0, 1, 64'h0123_4567_89AB_CDEF);
    vecs[16] = mk(1, 1, 3'b011, 32'h210, 64'h1122_3344_5566_7788, 5'd17, 64'h0, 1,
                  32'h210, 8'hFF, 64'h1122_3344_5566_7788, 0, 0, 64'h0);
    vecs[17] = mk(1, 0, 3'b010, 32'h20C, 64'h0, 5'd18, 64'h8765_4321_0000_0000, 1,
                  32'h208, 8'hF0, 64'h0, 0, 1, 64'hFFFF_FFFF_8765_4321);
    vecs[18] = mk(1, 1, 3'b000, 32'h207, 64'h5A, 5'd19, 64'h0, 1, 32'h200, 8'h80,
                  64'h5A5A_5A5A_5A5A_5A5A, 0, 0, 64'h0);
    vecs[19] = mk(1, 0, 3'b011, 32'h204, 64'h0, 5'd20, 64'h0, 0, 32'h0, 8'h00,
                  64'h0, 1, 0, 64'h0);

    // Reset state of both instances.
    repeat (2) @(negedge clk);
    chk("rst32_ready", {65'd0, r32_req_ready}, 66'd1);
    chk("rst32_quiet", {62'd0, r32_busy, r32_bus_valid, r32_resp_valid, r32_resp_err}, 66'd0);
    chk("rst64_ready", {65'd0, r64_req_ready}, 66'd1);
    chk("rst64_quiet", {62'd0, r64_busy, r64_bus_valid, r64_resp_valid, r64_resp_err}, 66'd0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Timeout with no reply, then reply in the expiry cycle.
    tmo_seq(0);
    tmo_seq(4);

    // Requests presented while busy are neither accepted nor queued.
    sel = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h500; req_rd = 5'd9;
    exp_q.push_back({1'b0, 1'b1, 64'h11223344});
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h600; req_wdata = 64'hFFFF;
    chk("busy_in_bus", {64'd0, o_busy, o_req_ready}, 66'd2);
    @(negedge clk);
    chk("bus_addr_held", {34'd0, o_bus_addr}, 66'h500);
    req_valid = 1'b0;
    bus_ready = 1'b1; bus_rdata = 64'h11223344;
    @(negedge clk);
    bus_ready = 1'b0;
    if (o_resp_valid) check_resp();
    else chk("ignore_resp_missing", 66'd0, 66'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ignore_not_queued", {64'd0, o_resp_valid, o_bus_valid}, 66'd0);
    end

    // Asynchronous reset in the middle of a bus access.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h400; req_rd = 5'd3;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_reset_bus_valid", {65'd0, o_bus_valid}, 66'd1);
    #2 reset = 1'b0;
    #1 chk("reset_drops_bus", {64'd0, o_bus_valid, o_req_ready}, 66'd1);
    repeat (2) begin
      @(negedge clk);
      chk("reset_no_resp", {65'd0, o_resp_valid}, 66'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {63'd0, o_resp_valid, o_bus_valid, o_req_ready}, 66'd1);
    run_vec(vecs[7]);

    @(negedge clk);
    chk("exp_q_drained", 66'(exp_q.size()), 66'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
